// File: rtl/exibe_sequencia.sv
// Plays the stored sequence back on the LEDs: each entry is lit for TEMPO_ON cycles
// and followed by TEMPO_OFF dark cycles, then completion is flagged to the controller.
module exibe_sequencia #(
    parameter int TEMPO_ON  = 500,
    parameter int TEMPO_OFF = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       mostrando,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int TMAX = (TEMPO_ON > TEMPO_OFF) ? TEMPO_ON : TEMPO_OFF;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] ON_LAST  = TW'(TEMPO_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(TEMPO_OFF - 1);

    typedef enum logic [3:0] {
        inicial    = 4'h0,
        preparacao = 4'h1,
        carrega    = 4'h2,
        acende     = 4'h3,
        apaga      = 4'h4,
        proximo    = 4'h5,
        fim        = 4'hF
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic [3:0]    limite_reg;
    logic [3:0]    dado_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= inicial;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            inicial:    if (iniciar) state_next = preparacao;
            preparacao: state_next = carrega;
            carrega:    state_next = acende;
            acende:     if (timer == ON_LAST) state_next = apaga;
            apaga: begin
                if (timer == OFF_LAST)
                    state_next = (endereco == limite_reg) ? fim : proximo;
            end
            proximo:    state_next = carrega;
            fim:        if (iniciar) state_next = preparacao;
            default:    state_next = inicial;
        endcase
    end

    // Timer restarts on every state change so each timed state counts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            timer <= '0;
        else if (state_next != state)
            timer <= '0;
        else if (state == acende || state == apaga)
            timer <= timer + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco   <= 4'h0;
            limite_reg <= 4'h0;
            dado_reg   <= 4'h0;
        end else begin
            case (state)
                inicial, fim: if (iniciar) limite_reg <= limite;
                preparacao:   endereco <= 4'h0;
                carrega:      dado_reg <= dado;
                proximo:      endereco <= endereco + 4'h1;
                default:      ;
            endcase
        end
    end

    always_comb begin
        leds      = (state == acende) ? dado_reg : 4'h0;
        mostrando = (state != inicial) && (state != fim);
        pronto    = (state == fim);
        db_estado = state;
    end

endmodule
